taxi_sgmii_an_monitor: RTL and testbench

- Consumes the 16-bit status vector from the SGMII PCS/PMA core and closes the loop back into that core.
- Qualifies link-up, decodes the negotiated speed and duplex, and drives the registered speed_is_10_100 and speed_is_100 controls.
- Pulses an_restart_config when the link fails to come up within a timeout, and keeps saturating link-down and restart counters.
- Sits in the PHY GMII clock domain, between the PCS core and fpga_core.

---
 rtl/taxi_sgmii_pkg.sv | 38 +++
 rtl/taxi_sat_counter.sv | 20 ++
 rtl/taxi_sgmii_an_monitor.sv | 197 +++++++++++++++++++
 tb/tb_taxi_sgmii_an_monitor.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_sgmii_pkg.sv
// SGMII autoneg monitor shared definitions:
// status-vector bit map, speed and FSM encodings.
package taxi_sgmii_pkg;

  localparam int LINK_STATUS = 0;
  localparam int SYNC        = 1;
  localparam int PHY_LINK    = 7;
  localparam int SPEED_LSB   = 10;
  localparam int DUPLEX      = 12;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10
  } speed_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINK = 3'd1,
    QUALIFY   = 3'd2,
    UP        = 3'd3,
    RESTART   = 3'd4
  } an_state_t;

  // Reserved code 2'b11 is treated as gigabit.
  function automatic speed_t decode_speed(
    input logic [1:0] raw
  );
    speed_t s;
    unique case (raw)
      2'b00:   s = SPEED_10;
      2'b01:   s = SPEED_100;
      default: s = SPEED_1000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/taxi_sat_counter.sv
// Saturating event counter: counts inc pulses,
// sticks at all-ones.
module taxi_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/taxi_sgmii_an_monitor.sv
// SGMII autoneg monitor: qualifies link, latches
// speed/duplex, and auto-restarts autoneg on timeout.
module taxi_sgmii_an_monitor
  import taxi_sgmii_pkg::*;
#(
  parameter int LINK_TIMEOUT_CYCLES  = 125000000,
  parameter int LINK_STABLE_CYCLES   = 1250000,
  parameter int RESTART_PULSE_CYCLES = 4,
  parameter int REQUIRE_PHY_LINK     = 1,
  parameter int CNT_W                = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart_req,
  input  logic [15:0]      status_vector,
  output logic             an_restart,
  output logic             speed_is_10_100,
  output logic             speed_is_100,
  output logic             link_up,
  output logic [1:0]       speed,
  output logic             duplex,
  output logic [CNT_W-1:0] link_down_count,
  output logic [CNT_W-1:0] restart_count,
  output logic [2:0]       state
);

  localparam int TMO_W = $clog2(LINK_TIMEOUT_CYCLES) + 1;
  localparam int STB_W = $clog2(LINK_STABLE_CYCLES) + 1;
  localparam int PLS_W = $clog2(RESTART_PULSE_CYCLES) + 1;

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(LINK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST =
    STB_W'(LINK_STABLE_CYCLES - 1);
  localparam logic [PLS_W-1:0] PLS_LAST =
    PLS_W'(RESTART_PULSE_CYCLES - 1);

  an_state_t        state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [STB_W-1:0] stb_q, stb_d;
  logic [PLS_W-1:0] pls_q, pls_d;
  logic             down_inc, rst_inc, latch;
  logic             an_restart_d, link_up_d;
  logic             link_good;
  speed_t           dec_speed, speed_q;
  logic             duplex_q;
  logic             unused_status;

  assign link_good = status_vector[LINK_STATUS]
                   & status_vector[SYNC]
                   & (status_vector[PHY_LINK]
                      | (REQUIRE_PHY_LINK == 0));

  assign dec_speed = decode_speed(
    status_vector[SPEED_LSB+1:SPEED_LSB]);

  assign unused_status = ^{status_vector[15:13],
                           status_vector[9:8],
                           status_vector[6:2]};

  // Timeout holds at its last value so QUALIFY can't wrap it.
  assign tmo_inc = (tmo_q == TMO_LAST) ? tmo_q
                                       : tmo_q + TMO_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LINK;
      tmo_q   <= '0;
      stb_q   <= '0;
      pls_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      stb_q   <= stb_d;
      pls_q   <= pls_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    stb_d    = stb_q;
    pls_d    = pls_q;
    down_inc = 1'b0;
    latch    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      tmo_d   = '0;
      stb_d   = '0;
      pls_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT_LINK;
        end
        WAIT_LINK: begin
          tmo_d = tmo_inc;
          if (restart_req) begin
            state_d = RESTART;
          end else if (link_good) begin
            state_d = QUALIFY;
            stb_d   = '0;
          end else if (tmo_q == TMO_LAST) begin
            state_d = RESTART;
          end
        end
        QUALIFY: begin
          tmo_d = tmo_inc;
          if (restart_req) begin
            state_d = RESTART;
          end else if (!link_good) begin
            state_d = WAIT_LINK;
          end else if (stb_q == STB_LAST) begin
            state_d = UP;
            latch   = 1'b1;
          end else begin
            stb_d = stb_q + STB_W'(1);
          end
        end
        UP: begin
          down_inc = !link_good;
          if (restart_req) begin
            state_d = RESTART;
          end else if (!link_good) begin
            state_d = WAIT_LINK;
            tmo_d   = '0;
          end else begin
            latch = (dec_speed != speed_q);
          end
        end
        RESTART: begin
          if (pls_q == PLS_LAST) begin
            state_d = WAIT_LINK;
            tmo_d   = '0;
          end else begin
            pls_d = pls_q + PLS_W'(1);
          end
        end
        default: begin
          state_d = WAIT_LINK;
          tmo_d   = '0;
        end
      endcase
      if (state_d == RESTART && state_q != RESTART) begin
        pls_d = '0;
        tmo_d = '0;
      end
    end
  end

  always_comb begin
    an_restart_d = (state_d == RESTART);
    link_up_d    = (state_d == UP);
    rst_inc      = (state_d == RESTART)
                 && (state_q != RESTART);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_restart      <= 1'b0;
      link_up         <= 1'b0;
      speed_q         <= SPEED_1000;
      duplex_q        <= 1'b1;
      speed_is_10_100 <= 1'b0;
      speed_is_100    <= 1'b0;
    end else begin
      an_restart      <= an_restart_d;
      link_up         <= link_up_d;
      speed_is_10_100 <= (speed_q != SPEED_1000);
      speed_is_100    <= (speed_q == SPEED_100);
      if (latch) begin
        speed_q  <= dec_speed;
        duplex_q <= status_vector[DUPLEX];
      end
    end
  end

  taxi_sat_counter #(.CNT_W(CNT_W)) u_down_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (down_inc),
    .count (link_down_count)
  );

  taxi_sat_counter #(.CNT_W(CNT_W)) u_rst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rst_inc),
    .count (restart_count)
  );

  assign speed  = speed_q;
  assign duplex = duplex_q;
  assign state  = state_q;

endmodule

// File: tb/tb_taxi_sgmii_an_monitor.sv
// Bench for taxi_sgmii_an_monitor: directed plus random
// stimulus, per-cycle scoreboard against a reference model.
module tb_taxi_sgmii_an_monitor;
  import taxi_sgmii_pkg::*;

  localparam int T  = 100;
  localparam int S  = 10;
  localparam int P  = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable = 1'b0;
  logic          restart_req = 1'b0;
  logic [15:0]   status_vector = 16'h0;
  logic          an_restart;
  logic          speed_is_10_100;
  logic          speed_is_100;
  logic          link_up;
  logic [1:0]    speed;
  logic          duplex;
  logic [CW-1:0] link_down_count;
  logic [CW-1:0] restart_count;
  logic [2:0]    state;

  taxi_sgmii_an_monitor #(
    .LINK_TIMEOUT_CYCLES  (T),
    .LINK_STABLE_CYCLES   (S),
    .RESTART_PULSE_CYCLES (P),
    .REQUIRE_PHY_LINK     (1),
    .CNT_W                (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .restart_req     (restart_req),
    .status_vector   (status_vector),
    .an_restart      (an_restart),
    .speed_is_10_100 (speed_is_10_100),
    .speed_is_100    (speed_is_100),
    .link_up         (link_up),
    .speed           (speed),
    .duplex          (duplex),
    .link_down_count (link_down_count),
    .restart_count   (restart_count),
    .state           (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          anr;
    logic          lu;
    logic [1:0]    spd;
    logic          dup;
    logic          s1;
    logic          s2;
    logic [CW-1:0] dn;
    logic [CW-1:0] rc;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode plus elapsed-time bookkeeping.
  an_state_t m_st;
  int  waited, run, pulse_left;
  int  m_spd, m_dn, m_rc;
  bit  m_dup, m_s1, m_s2;

  task automatic model_reset();
    m_st = WAIT_LINK;
    waited = 0;
    run = 0;
    pulse_left = 0;
    m_spd = 2;
    m_dup = 1'b1;
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_dn = 0;
    m_rc = 0;
  endtask

  task automatic bump(inout int x);
    if (x < CMAX) x++;
  endtask

  task automatic go_restart();
    m_st = RESTART;
    pulse_left = P;
    bump(m_rc);
  endtask

  task automatic model_step(input bit en, input bit req,
                            input logic [15:0] sv);
    bit good;
    int dspd, old_spd;
    logic [1:0] raw;
    good = sv[0] && sv[1] && sv[7];
    raw = sv[11:10];
    dspd = (raw == 2'b11) ? 2 : int'(raw);
    old_spd = m_spd;
    if (!en) begin
      m_st = IDLE;
      waited = 0;
    end else begin
      case (m_st)
        IDLE: begin
          m_st = WAIT_LINK;
          waited = 0;
        end
        WAIT_LINK: begin
          if (req) go_restart();
          else if (good) begin
            m_st = QUALIFY;
            run = 0;
            waited++;
          end else if (waited >= T - 1) go_restart();
          else waited++;
        end
        QUALIFY: begin
          if (req) go_restart();
          else if (!good) begin
            m_st = WAIT_LINK;
            waited++;
          end else begin
            run++;
            waited++;
            if (run == S) begin
              m_st = UP;
              m_spd = dspd;
              m_dup = sv[12];
            end
          end
        end
        UP: begin
          if (!good) bump(m_dn);
          if (req) go_restart();
          else if (!good) begin
            m_st = WAIT_LINK;
            waited = 0;
          end else if (dspd != m_spd) begin
            m_spd = dspd;
            m_dup = sv[12];
          end
        end
        RESTART: begin
          pulse_left--;
          if (pulse_left == 0) begin
            m_st = WAIT_LINK;
            waited = 0;
          end
        end
        default: m_st = WAIT_LINK;
      endcase
    end
    m_s1 = (old_spd != 2);
    m_s2 = (old_spd == 1);
  endtask

  task automatic cyc(input bit en, input bit req,
                     input logic [15:0] sv);
    obs_t e;
    @(negedge clk);
    rst_n = 1'b1;
    enable = en;
    restart_req = req;
    status_vector = sv;
    model_step(en, req, sv);
    e.st  = m_st;
    e.anr = (m_st == RESTART);
    e.lu  = (m_st == UP);
    e.spd = 2'(m_spd);
    e.dup = m_dup;
    e.s1  = m_s1;
    e.s2  = m_s2;
    e.dn  = CW'(m_dn);
    e.rc  = CW'(m_rc);
    exp_q.push_back(e);
  endtask

  function automatic obs_t sample();
    obs_t a;
    a.st  = state;
    a.anr = an_restart;
    a.lu  = link_up;
    a.spd = speed;
    a.dup = duplex;
    a.s1  = speed_is_10_100;
    a.s2  = speed_is_100;
    a.dn  = link_down_count;
    a.rc  = restart_count;
    return a;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a = sample();
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL cycle_out t=%0t act=%h req=%h st %0d/%0d anr %b/%b lu %b/%b spd %0d/%0d dup %b/%b s1010 %b/%b s100 %b/%b dn %0d/%0d rc %0d/%0d",
                   $time, mon_a, mon_e, mon_a.st, mon_e.st,
                   mon_a.anr, mon_e.anr, mon_a.lu, mon_e.lu,
                   mon_a.spd, mon_e.spd, mon_a.dup, mon_e.dup,
                   mon_a.s1, mon_e.s1, mon_a.s2, mon_e.s2,
                   mon_a.dn, mon_e.dn, mon_a.rc, mon_e.rc);
      end
    end
  end

  task automatic check_reset(input string name);
    obs_t a, r;
    a = sample();
    r = '{st: 3'd1, anr: 1'b0, lu: 1'b0, spd: 2'b10,
          dup: 1'b1, s1: 1'b0, s2: 1'b0, dn: '0, rc: '0};
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, r);
    end
  endtask

  task automatic check_bit(input string name,
                           input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_state");

    // Gigabit (reserved speed code) link from reset release.
    repeat (10) cyc(1, 0, 16'h0C83);
    @(posedge clk);
    #2;
    check_bit("link_up_early", link_up, 1'b0);
    cyc(1, 0, 16'h0C83);
    @(posedge clk);
    #2;
    check_bit("link_up_latency", link_up, 1'b1);
    repeat (5) cyc(1, 0, 16'h0C83);

    // No link: timeout restarts twice.
    repeat (230) cyc(1, 0, 16'h1000);

    // 100M link, single-cycle drop, requalify.
    repeat (25) cyc(1, 0, 16'h1483);
    cyc(1, 0, 16'h1482);
    repeat (20) cyc(1, 0, 16'h1483);

    // Flapping link never qualifies.
    cyc(0, 0, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      repeat (5) cyc(1, 0, 16'h0C83);
      repeat (5) cyc(1, 0, 16'h0C80);
    end

    // Drop coinciding with manual restart.
    repeat (25) cyc(1, 0, 16'h1483);
    cyc(1, 1, 16'h1482);
    repeat (20) cyc(1, 0, 16'h1483);

    // Forced restarts until the counter saturates.
    repeat (3) cyc(1, 0, 16'h1000);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 16'h1000);
      repeat (5) cyc(1, 0, 16'h1000);
    end
    @(posedge clk);
    #2;
    checks++;
    if (restart_count !== 4'hF) begin
      errors++;
      $display("FAIL restart_sat actual=%h required=f",
               restart_count);
    end

    // Disable in the middle of a restart pulse.
    cyc(1, 1, 16'h1000);
    repeat (2) cyc(1, 0, 16'h1000);
    @(posedge clk);
    #2;
    check_bit("anr_before_abort", an_restart, 1'b1);
    repeat (3) cyc(0, 0, 16'h1000);
    repeat (5) cyc(1, 0, 16'h1000);

    // Random traffic.
    for (int k = 0; k < 150; k++) begin
      logic [15:0] sv;
      int hold;
      sv = 16'($urandom);
      sv[0] = 1'b1;
      sv[1] = 1'b1;
      sv[7] = 1'b1;
      case ($urandom_range(0, 5))
        0: sv[0] = 1'b0;
        1: sv[1] = 1'b0;
        2: sv[7] = 1'b0;
        default: ;
      endcase
      hold = $urandom_range(1, 25);
      repeat (hold)
        cyc($urandom_range(0, 60) != 0,
            $urandom_range(0, 80) == 0, sv);
    end

    // Async reset while qualifying.
    cyc(0, 0, 16'h0C83);
    repeat (5) cyc(1, 0, 16'h0C83);
    @(posedge clk);
    #2;
    check_bit("in_qualify", state == 3'd2, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    repeat (30) cyc(1, 0, 16'h1483);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
